dictionary_load_ctrl: RTL
=========================

# dictionary_load_ctrl

Sequencer and access arbiter for one dictionary field. At start-up it streams 2**KEY_WIDTH dictionary entries from a boot source into the dictionary's sequential write port, retrying when the source stalls mid-burst. Once the dictionary is loaded, it shares the dictionary's key-lookup port between two decompressor requesters using round-robin arbitration and returns registered results.

## Interface
- KEY_WIDTH, 8, dictionary index width; the dictionary holds 2**KEY_WIDTH entries.
- VAL_WIDTH, 15, width of each uncompressed field value.
- MAX_RETRIES, 3, number of load attempts allowed before the block enters FAIL (minimum 1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a (re)load; sampled in IDLE, READY and FAIL.
- src_valid  in  1  source word valid.
- src_data  in  VAL_WIDTH  source word.
- src_ready  out  1  loader accepts a word this cycle.
- src_rewind  out  1  one-cycle pulse that tells the source to restart at entry 0.
- dict_write_enable  out  1  drives the dictionary write enable.
- dict_write_val  out  VAL_WIDTH  drives the dictionary write data.
- dict_key_lookup  out  KEY_WIDTH  drives the dictionary lookup key.
- dict_val_in  in  VAL_WIDTH  combinational value returned by the dictionary for dict_key_lookup.
- req0_valid / req1_valid  in  1  lookup request from requester 0 / 1.
- req0_key / req1_key  in  KEY_WIDTH  key to look up.
- req0_ready / req1_ready  out  1  the request is granted this cycle.
- rsp_valid  out  1  lookup result valid.
- rsp_id  out  1  requester that the result belongs to.
- rsp_val  out  VAL_WIDTH  looked-up value.
- loaded  out  1  dictionary contents are valid.
- busy  out  1  a load is in progress (REWIND or LOAD state).
- error  out  1  load failed (FAIL state).

## Operation
The dictionary advances its write index only while write_enable is high and resets the index to 0 on any low cycle. A load is therefore valid only as one gapless burst of 2**KEY_WIDTH writes.

States:
- IDLE
  - State after reset.
  - start goes to REWIND with retry_cnt = 0.
- REWIND
  - Lasts one cycle.
  - src_rewind = 1, dict_write_enable = 0, cnt = 0.
  - Always goes to LOAD.
- LOAD
  - src_ready = 1.
  - dict_write_enable = src_valid and dict_write_val = src_data (both combinational).
  - Each cycle with src_valid = 1 increments cnt (KEY_WIDTH bits).
  - src_valid with cnt at all-ones goes to READY. This is the final word.
  - src_valid = 0 with cnt = 0 means the source has not started yet: wait, no penalty.
  - src_valid = 0 with cnt ≠ 0 is a gap: retry_cnt increments. If the new retry_cnt equals MAX_RETRIES, go to FAIL; otherwise go to REWIND.
- READY
  - loaded = 1. Arbitration is active.
  - start goes to REWIND: loaded drops and retry_cnt clears. A request presented in that same cycle is not granted.
- FAIL
  - error = 1.
  - start goes to REWIND with retry_cnt cleared; error drops.
- start is ignored in REWIND and LOAD.

Arbitration (READY only):
- At most one grant per cycle.
- Priority pointer rr resets to 0, which favours requester 0.
- If only one requester is valid, it is granted.
- If both are valid, requester rr is granted.
- After any grant, rr points to the requester that was not granted.
- The granted key drives dict_key_lookup. dict_val_in is registered into rsp_val, with rsp_id = the granted requester and rsp_valid = 1 on the next cycle.
- If no request is granted, dict_key_lookup holds its last value and rsp_valid is 0 next cycle.
- Outside READY, both req*_ready = 0.

Reset values:
- state = IDLE; cnt, retry_cnt and rr = 0.
- All outputs are 0, including rsp_val, dict_key_lookup, loaded, busy and error.

## Timing
- start sampled at edge t → REWIND during cycle t+1 → LOAD from t+2.
- With a gapless source, the final word is written in cycle t+1+2**KEY_WIDTH. loaded = 1 and busy = 0 from cycle t+2+2**KEY_WIDTH.
- A gap is detected in the cycle src_valid is low. The next cycle is REWIND, or FAIL if the retry limit is reached.
- Lookup latency: grant at cycle n → rsp_valid, rsp_id and rsp_val at cycle n+1.
- Requesters may present back-to-back requests; the block sustains one response per cycle.
- Asserting reset mid-LOAD returns the block to IDLE immediately. dict_write_enable drops asynchronously, and the dictionary index clears on its next clock.

## Test plan
Bench uses KEY_WIDTH=2, VAL_WIDTH=15, MAX_RETRIES=3.
- Clean load: pulse start, then source sends 0x0011, 0x0022, 0x0033, 0x0044 gaplessly → exactly one src_rewind pulse; four writes in consecutive cycles; loaded = 1 on the cycle after the last write; looking up key 2 returns 0x0033.
- Stalls: source idles 3 cycles before the first word, then streams gaplessly → no retry, loaded = 1. Separately, a gap after the 2nd word → second src_rewind pulse, retry_cnt = 1; the reload then completes with the correct contents.
- Retry exhaustion: a gap after the 1st word on three consecutive attempts → state FAIL, error = 1, loaded = 0. A later start followed by a clean stream → error = 0, loaded = 1.
- Arbitration: both requesters valid every cycle, req0_key = 1 and req1_key = 3 → grants alternate req0, req1, req0, …; responses 0x0022 (id 0) and 0x0044 (id 1) alternate, each arriving one cycle after its grant.
- Gating and reset: requests while busy → req*_ready = 0 and no rsp_valid. reset asserted mid-LOAD → all outputs 0 immediately; a following start reloads cleanly.
- Reload from READY: start with req0 valid in the same cycle → no grant that cycle, loaded drops, a new load completes, and req0 is then served with the new contents.

Source files
------------

// File: rtl/dictionary_load_ctrl.sv
// dictionary_load_ctrl
//
// Loads one dictionary field from a boot source, then shares the dictionary's
// lookup port between two decompressor requesters.
//
// Load: after start, the source is rewound and then streamed into the
// dictionary's sequential write port. The dictionary only accepts one gapless
// burst of 2**KEY_WIDTH writes, so a source stall after the first word forces
// a rewind and a retry. MAX_RETRIES failed attempts park the block in FAIL.
//
// Lookup: once loaded, a round-robin arbiter grants at most one requester per
// cycle. Its key drives the dictionary combinationally, and the returned value
// is registered as the response one cycle later.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 (re)load request, honoured in IDLE, READY and FAIL
//   src_valid/src_data    boot source word
//   src_ready/src_rewind  loader accepting / restart source at entry 0
//   dict_write_enable/dict_write_val  dictionary sequential write port
//   dict_key_lookup/dict_val_in       dictionary lookup port
//   req{0,1}_valid/_key/_ready        requester handshakes
//   rsp_valid/rsp_id/rsp_val          registered lookup result
//   loaded/busy/error                 status
module dictionary_load_ctrl #(
    parameter int unsigned KEY_WIDTH   = 8,
    parameter int unsigned VAL_WIDTH   = 15,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 src_valid,
    input  logic [VAL_WIDTH-1:0] src_data,
    output logic                 src_ready,
    output logic                 src_rewind,
    output logic                 dict_write_enable,
    output logic [VAL_WIDTH-1:0] dict_write_val,
    output logic [KEY_WIDTH-1:0] dict_key_lookup,
    input  logic [VAL_WIDTH-1:0] dict_val_in,
    input  logic                 req0_valid,
    input  logic [KEY_WIDTH-1:0] req0_key,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [KEY_WIDTH-1:0] req1_key,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [VAL_WIDTH-1:0] rsp_val,
    output logic                 loaded,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned RetryWidth = $clog2(MAX_RETRIES + 1);
    localparam logic [RetryWidth-1:0] RetryLimit = RetryWidth'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle,
        StRewind,
        StLoad,
        StReady,
        StFail
    } state_e;

    state_e                state_q, state_d;
    logic [KEY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [RetryWidth-1:0] retry_cnt_q, retry_cnt_d;
    logic                  rr_q, rr_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [VAL_WIDTH-1:0]  rsp_val_q, rsp_val_d;
    logic                  src_rewind_q, src_rewind_d;
    logic                  loaded_q, loaded_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;

    logic arb_en;
    logic grant0;
    logic grant1;

    // Arbitration and lookup path. A start seen in READY suppresses grants so
    // no lookup is served against contents that are about to be rewritten.
    always_comb begin
        arb_en = (state_q == StReady) && !start;
        grant0 = arb_en && req0_valid && (!req1_valid || !rr_q);
        grant1 = arb_en && req1_valid && (!req0_valid || rr_q);

        rr_d = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end

        // The lookup key holds its last value when nothing is granted.
        if (grant1) begin
            dict_key_lookup = req1_key;
        end else if (grant0) begin
            dict_key_lookup = req0_key;
        end else begin
            dict_key_lookup = key_q;
        end
        key_d = dict_key_lookup;

        rsp_valid_d = grant0 || grant1;
        rsp_id_d    = grant1;
        rsp_val_d   = (grant0 || grant1) ? dict_val_in : rsp_val_q;

        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Loader write path is combinational so each accepted source word lands
    // in the dictionary in the same cycle, keeping the burst gapless.
    always_comb begin
        src_ready         = (state_q == StLoad);
        dict_write_enable = (state_q == StLoad) && src_valid;
        dict_write_val    = (state_q == StLoad) ? src_data : '0;
    end

    // Load sequencer next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_cnt_d = retry_cnt_q;

        unique case (state_q)
            StIdle, StReady, StFail: begin
                if (start) begin
                    state_d     = StRewind;
                    retry_cnt_d = '0;
                end
            end
            StRewind: begin
                cnt_d   = '0;
                state_d = StLoad;
            end
            StLoad: begin
                if (src_valid) begin
                    cnt_d = cnt_q + KEY_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_d = StReady;
                    end
                end else if (cnt_q != '0) begin
                    // A stall mid-burst breaks the dictionary's write sequence.
                    retry_cnt_d = retry_cnt_q + RetryWidth'(1);
                    state_d     = (retry_cnt_d == RetryLimit) ? StFail : StRewind;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        src_rewind_d = (state_d == StRewind);
        loaded_d     = (state_d == StReady);
        busy_d       = (state_d == StRewind) || (state_d == StLoad);
        error_d      = (state_d == StFail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            retry_cnt_q  <= '0;
            rr_q         <= 1'b0;
            key_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_val_q    <= '0;
            src_rewind_q <= 1'b0;
            loaded_q     <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            rr_q         <= rr_d;
            key_q        <= key_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_val_q    <= rsp_val_d;
            src_rewind_q <= src_rewind_d;
            loaded_q     <= loaded_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign src_rewind = src_rewind_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_val    = rsp_val_q;
    assign loaded     = loaded_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule
